// File: rtl/qbert_pkg.sv
// Shared types, pyramid geometry and move table for the Qbert hop sequencer.
package qbert_pkg;

  typedef enum logic [2:0] {S_IDLE, S_HOP, S_FALL, S_DONE, S_OVER} state_t;

  typedef enum logic [1:0] {
    DIR_DL = 2'd0,
    DIR_DR = 2'd1,
    DIR_UL = 2'd2,
    DIR_UR = 2'd3
  } dir_t;

  typedef logic [2:0] cube_t;

  localparam cube_t CUBE_OFF  = 3'd7;
  localparam int    NUM_CUBES = 6;

  localparam int XLENGTH        = 55;
  localparam int XDIAG_DEMI     = 30;
  localparam int YDIAG_DEMI     = 50;
  localparam int RANK1_X_OFFSET = 600;
  localparam int RANK1_Y_OFFSET = 90;

  // Renderer places each rank one cube-width plus half-diagonal left, with a one-pixel seam.
  localparam logic [10:0] RANK1_X = 11'(RANK1_X_OFFSET);
  localparam logic [10:0] RANK2_X = 11'(RANK1_X_OFFSET - XLENGTH - XDIAG_DEMI - 1);
  localparam logic [10:0] RANK3_X = 11'(RANK1_X_OFFSET - 2 * (XLENGTH + XDIAG_DEMI) - 1);

  localparam logic [9:0] Y_C0 = 10'(RANK1_Y_OFFSET + 2 * YDIAG_DEMI);
  localparam logic [9:0] Y_C1 = 10'(RANK1_Y_OFFSET + YDIAG_DEMI);
  localparam logic [9:0] Y_C2 = 10'(RANK1_Y_OFFSET + 3 * YDIAG_DEMI + 1);
  localparam logic [9:0] Y_C3 = 10'(RANK1_Y_OFFSET);
  localparam logic [9:0] Y_C4 = 10'(RANK1_Y_OFFSET + 2 * YDIAG_DEMI + 1);
  localparam logic [9:0] Y_C5 = 10'(RANK1_Y_OFFSET + 4 * YDIAG_DEMI + 1);

  // Packed with cube 5 leftmost so CUBE_X[c] selects cube c.
  localparam logic [NUM_CUBES-1:0][10:0] CUBE_X =
    {RANK1_X, RANK1_X, RANK1_X, RANK2_X, RANK2_X, RANK3_X};
  localparam logic [NUM_CUBES-1:0][9:0] CUBE_Y =
    {Y_C5, Y_C4, Y_C3, Y_C2, Y_C1, Y_C0};

  // Each entry is {ur, ul, dr, dl}, so NEXT_MAP[c][d] is the destination for direction d.
  localparam logic [NUM_CUBES-1:0][3:0][2:0] NEXT_MAP = {
    {CUBE_OFF, 3'd2,     CUBE_OFF, CUBE_OFF},
    {3'd2,     3'd1,     CUBE_OFF, CUBE_OFF},
    {3'd1,     CUBE_OFF, CUBE_OFF, CUBE_OFF},
    {CUBE_OFF, 3'd0,     3'd5,     3'd4},
    {3'd0,     CUBE_OFF, 3'd4,     3'd3},
    {CUBE_OFF, CUBE_OFF, 3'd2,     3'd1}
  };

  function automatic cube_t next_cube(cube_t c, dir_t d);
    if (c > 3'd5) return CUBE_OFF;
    return NEXT_MAP[c][d];
  endfunction

endpackage

// File: rtl/qbert_frame_timer.sv
// Counts frame ticks up to a target and pulses done on the tick that reaches it.
module qbert_frame_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             tick,
  input  logic [WIDTH-1:0] target,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Combinational so the owner can land on the same edge that samples the final tick.
  assign done = enable && !clear && tick && (count == target - WIDTH'(1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              count <= '0;
    else if (clear)         count <= '0;
    else if (enable && tick) count <= done ? '0 : count + WIDTH'(1);
  end

endmodule

// File: rtl/qbert_move_ctrl.sv
// Hop/fall sequencer for Qbert on the 6-cube pyramid: move handshake, sprite offsets, visit mask, lives.
module qbert_move_ctrl
  import qbert_pkg::*;
#(
  parameter int HOP_FRAMES  = 8,
  parameter int FALL_FRAMES = 30,
  parameter int LIVES       = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        restart,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  output logic        move_ready,
  output logic [10:0] qbert_x_offset,
  output logic [9:0]  qbert_y_offset,
  output logic        hopping,
  output logic        falling,
  output logic [5:0]  cube_visited,
  output logic [1:0]  lives,
  output logic        level_done,
  output logic        game_over
);

  localparam int MAX_FRAMES = (HOP_FRAMES > FALL_FRAMES) ? HOP_FRAMES : FALL_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

  state_t      state, state_d;
  cube_t       pos, pos_d, dst, dst_d, nxt;
  logic [5:0]  vis, vis_d;
  logic [1:0]  lives_q, lives_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        timer_done;

  assign nxt = next_cube(pos, dir_t'(move_dir));

  qbert_frame_timer #(.WIDTH(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (restart || state == S_IDLE),
    .enable (state == S_HOP || state == S_FALL),
    .tick   (frame_tick),
    .target ((state == S_HOP) ? CNT_W'(HOP_FRAMES) : CNT_W'(FALL_FRAMES)),
    .done   (timer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pos     <= 3'd0;
      dst     <= 3'd0;
      vis     <= 6'b000001;
      lives_q <= 2'(LIVES);
      x_q     <= CUBE_X[0];
      y_q     <= CUBE_Y[0];
    end else begin
      state   <= state_d;
      pos     <= pos_d;
      dst     <= dst_d;
      vis     <= vis_d;
      lives_q <= lives_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // NOTE: every signal gets a default first so no path through this block infers a latch.
  always_comb begin
    state_d = state;
    pos_d   = pos;
    dst_d   = dst;
    vis_d   = vis;
    lives_d = lives_q;
    x_d     = x_q;
    y_d     = y_q;

    unique case (state)
      S_IDLE: begin
        if (move_valid) begin
          dst_d   = nxt;
          state_d = (nxt != CUBE_OFF) ? S_HOP : S_FALL;
        end
      end
      S_HOP: begin
        if (timer_done) begin
          pos_d   = dst;
          vis_d   = vis | (6'b000001 << dst);
          x_d     = CUBE_X[dst];
          y_d     = CUBE_Y[dst];
          state_d = (&vis_d) ? S_DONE : S_IDLE;
        end
      end
      S_FALL: begin
        if (timer_done) begin
          lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
          if (lives_q <= 2'd1) begin
            state_d = S_OVER;
          end else begin
            pos_d   = 3'd0;
            x_d     = CUBE_X[0];
            y_d     = CUBE_Y[0];
            state_d = S_IDLE;
          end
        end
      end
      default: ;
    endcase

    // Soft restart overrides any landing, fall or accept on the same edge.
    if (restart) begin
      state_d = S_IDLE;
      pos_d   = 3'd0;
      dst_d   = 3'd0;
      vis_d   = 6'b000001;
      lives_d = 2'(LIVES);
      x_d     = CUBE_X[0];
      y_d     = CUBE_Y[0];
    end
  end

  assign move_ready     = (state == S_IDLE);
  assign hopping        = (state == S_HOP);
  assign falling        = (state == S_FALL);
  assign level_done     = (state == S_DONE);
  assign game_over      = (state == S_OVER);
  assign qbert_x_offset = x_q;
  assign qbert_y_offset = y_q;
  assign cube_visited   = vis;
  assign lives          = lives_q;

endmodule

// File: tb/tb_qbert_move_ctrl.sv
// Directed scoreboard bench for qbert_move_ctrl: hops, falls, level completion, game over, restart and reset.
module tb_qbert_move_ctrl;

  localparam int HOP  = 2;
  localparam int FALL = 3;
  localparam int LIV  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        restart = 1'b0;
  logic        move_valid = 1'b0;
  logic [1:0]  move_dir = 2'd0;
  logic        move_ready, hopping, falling, level_done, game_over;
  logic [10:0] qbert_x_offset;
  logic [9:0]  qbert_y_offset;
  logic [5:0]  cube_visited;
  logic [1:0]  lives;

  qbert_move_ctrl #(.HOP_FRAMES(HOP), .FALL_FRAMES(FALL), .LIVES(LIV)) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_tick     (frame_tick),
    .restart        (restart),
    .move_valid     (move_valid),
    .move_dir       (move_dir),
    .move_ready     (move_ready),
    .qbert_x_offset (qbert_x_offset),
    .qbert_y_offset (qbert_y_offset),
    .hopping        (hopping),
    .falling        (falling),
    .cube_visited   (cube_visited),
    .lives          (lives),
    .level_done     (level_done),
    .game_over      (game_over)
  );

  always #5 clk = ~clk;

  // Reference geometry and move table, written out cube by cube.
  int tb_x [6] = '{429, 514, 514, 600, 600, 600};
  int tb_y [6] = '{190, 140, 241, 90, 191, 291};
  int tb_next [6][4] = '{'{1, 2, 7, 7}, '{3, 4, 7, 0}, '{4, 5, 0, 7},
                         '{7, 7, 7, 1}, '{7, 7, 1, 2}, '{7, 7, 2, 7}};

  typedef struct {
    string       tag;
    logic [33:0] value;
  } exp_t;

  exp_t sb [$];
  int   vectors = 0;
  int   miscompares = 0;

  int         mpos = 0;
  logic [5:0] mvis = 6'b000001;
  logic [1:0] mlives = 2'(LIV);

  function automatic logic [33:0] st(bit rdy, bit hop, bit fall, bit dn, bit ov,
                                     logic [1:0] lv, logic [5:0] vis, int cube);
    return {rdy, hop, fall, dn, ov, lv, vis, 11'(tb_x[cube]), 10'(tb_y[cube])};
  endfunction

  function automatic logic [33:0] observed();
    return {move_ready, hopping, falling, level_done, game_over, lives, cube_visited,
            qbert_x_offset, qbert_y_offset};
  endfunction

  task automatic compare();
    exp_t e;
    logic [33:0] obs;
    e = sb.pop_front();
    obs = observed();
    vectors++;
    assert (obs === e.value) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.value);
    end
  endtask

  // Push the expectation for the edge about to be applied, then compare after it.
  task automatic cyc(string tag, logic [33:0] e);
    sb.push_back('{tag, e});
    @(negedge clk);
    compare();
  endtask

  task automatic model_restart();
    mpos = 0;
    mvis = 6'b000001;
    mlives = 2'(LIV);
  endtask

  task automatic finish_hop(int nxt, string tag);
    for (int i = 1; i <= HOP; i++) begin
      frame_tick = 1'b1;
      if (i < HOP) begin
        cyc({tag, "_hop"}, st(0, 1, 0, 0, 0, mlives, mvis, mpos));
      end else begin
        mpos = nxt;
        mvis = mvis | (6'b000001 << nxt);
        cyc({tag, "_land"}, st(mvis != 6'h3f, 0, 0, mvis == 6'h3f, 0, mlives, mvis, mpos));
      end
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic finish_fall(string tag);
    for (int i = 1; i <= FALL; i++) begin
      frame_tick = 1'b1;
      if (i < FALL) begin
        cyc({tag, "_fall"}, st(0, 0, 1, 0, 0, mlives, mvis, mpos));
      end else if (mlives == 2'd1) begin
        mlives = 2'd0;
        cyc({tag, "_over"}, st(0, 0, 0, 0, 1, mlives, mvis, mpos));
      end else begin
        mlives = mlives - 2'd1;
        mpos = 0;
        cyc({tag, "_lost"}, st(1, 0, 0, 0, 0, mlives, mvis, mpos));
      end
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic do_move(int dir, bit tick_on_accept, string tag);
    int nxt;
    nxt = tb_next[mpos][dir];
    move_valid = 1'b1;
    move_dir   = 2'(dir);
    frame_tick = tick_on_accept;
    cyc({tag, "_acc"}, st(0, nxt != 7, nxt == 7, 0, 0, mlives, mvis, mpos));
    move_valid = 1'b0;
    frame_tick = 1'b0;
    if (nxt != 7) finish_hop(nxt, tag);
    else          finish_fall(tag);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc("reset", st(1, 0, 0, 0, 0, mlives, mvis, mpos));

    // Off the top of the apex: one life lost, back on cube 0, mask untouched.
    do_move(2, 1'b0, "fall_ul");

    // Cover every cube; the sixth landing goes straight to DONE.
    do_move(0, 1'b0, "lvl1");
    do_move(0, 1'b0, "lvl2");
    do_move(3, 1'b0, "lvl3");
    do_move(1, 1'b0, "lvl4");
    do_move(3, 1'b0, "lvl5");
    do_move(1, 1'b0, "lvl6");
    move_valid = 1'b1;
    frame_tick = 1'b1;
    cyc("done_hold", st(0, 0, 0, 1, 0, mlives, mvis, mpos));
    move_valid = 1'b0;
    frame_tick = 1'b0;
    restart = 1'b1;
    model_restart();
    cyc("restart_done", st(1, 0, 0, 0, 0, mlives, mvis, mpos));
    restart = 1'b0;

    // Request held through a hop with a changed direction is taken only after landing.
    move_valid = 1'b1;
    move_dir   = 2'd0;
    cyc("held_acc", st(0, 1, 0, 0, 0, mlives, mvis, mpos));
    move_dir   = 2'd1;
    frame_tick = 1'b1;
    cyc("held_t1", st(0, 1, 0, 0, 0, mlives, mvis, mpos));
    frame_tick = 1'b0;
    cyc("held_gap", st(0, 1, 0, 0, 0, mlives, mvis, mpos));
    frame_tick = 1'b1;
    mpos = 1;
    mvis = mvis | 6'b000010;
    cyc("held_land", st(1, 0, 0, 0, 0, mlives, mvis, mpos));
    frame_tick = 1'b0;
    cyc("held_acc2", st(0, 1, 0, 0, 0, mlives, mvis, mpos));
    move_valid = 1'b0;
    finish_hop(4, "held2");

    // Tick coinciding with accept must not count toward the hop.
    do_move(2, 1'b1, "tick_acc");

    // Restart on the final hop tick wins: no landing on cube 3.
    move_valid = 1'b1;
    move_dir   = 2'd0;
    cyc("rst_hop_acc", st(0, 1, 0, 0, 0, mlives, mvis, mpos));
    move_valid = 1'b0;
    frame_tick = 1'b1;
    cyc("rst_hop_t1", st(0, 1, 0, 0, 0, mlives, mvis, mpos));
    frame_tick = 1'b0;
    @(negedge clk);
    frame_tick = 1'b1;
    restart    = 1'b1;
    model_restart();
    cyc("restart_tick", st(1, 0, 0, 0, 0, mlives, mvis, mpos));
    frame_tick = 1'b0;
    restart    = 1'b0;

    // Asynchronous reset partway through a hop takes effect without a clock edge.
    move_valid = 1'b1;
    move_dir   = 2'd1;
    cyc("arst_acc", st(0, 1, 0, 0, 0, mlives, mvis, mpos));
    move_valid = 1'b0;
    frame_tick = 1'b1;
    cyc("arst_t1", st(0, 1, 0, 0, 0, mlives, mvis, mpos));
    frame_tick = 1'b0;
    #2;
    reset = 1'b1;
    model_restart();
    sb.push_back('{"arst_now", st(1, 0, 0, 0, 0, mlives, mvis, mpos)});
    #1;
    compare();
    @(negedge clk);
    reset = 1'b0;
    do_move(1, 1'b0, "post_arst");
    do_move(2, 1'b0, "back_apex");

    // Three falls exhaust the lives; OVER ignores requests until restart.
    do_move(2, 1'b0, "f1");
    do_move(3, 1'b0, "f2");
    do_move(2, 1'b0, "f3");
    move_valid = 1'b1;
    move_dir   = 2'd0;
    frame_tick = 1'b1;
    cyc("over_hold", st(0, 0, 0, 0, 1, mlives, mvis, mpos));
    frame_tick = 1'b0;
    cyc("over_hold2", st(0, 0, 0, 0, 1, mlives, mvis, mpos));
    move_valid = 1'b0;
    restart = 1'b1;
    model_restart();
    cyc("restart_over", st(1, 0, 0, 0, 0, mlives, mvis, mpos));
    restart = 1'b0;
    cyc("idle_after", st(1, 0, 0, 0, 0, mlives, mvis, mpos));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
